// File: rtl/faust_sample_sched.sv
// faust_sample_sched
// Paces the Faust process_wrapper DSP core at a programmable sample rate. On each
// rate tick, one source sample is latched and the core's start and data tokens are
// issued. The block then waits for the end token and captures every out0 token onto
// a held output bus. Sticky flags report ticks that arrive while busy (overrun) and
// cores that never finish (timeout, watchdog abort).
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   enable               allow new transactions (gates the rate counter)
//   rate_div             tick period minus one
//   clr_flags            clear sticky overrun/timeout (a set in the same cycle wins)
//   src_sample/src_take  source sample and its one-cycle latch pulse
//   dsp_in0*/dsp_start*  data and start tokens to the core
//   dsp_out0*/dsp_end*   result and end tokens from the core (always accepted)
//   sample_out/strobe    last processed sample and its update pulse
//   busy/overrun/timeout status
module faust_sample_sched #(
  parameter int unsigned SAMPLE_WIDTH = 8,
  parameter int unsigned DIV_WIDTH    = 8,
  parameter int unsigned WDOG_CYCLES  = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [DIV_WIDTH-1:0]    rate_div,
  input  logic                    clr_flags,
  input  logic [SAMPLE_WIDTH-1:0] src_sample,
  output logic                    src_take,
  output logic [SAMPLE_WIDTH-1:0] dsp_in0,
  output logic                    dsp_in0_valid,
  input  logic                    dsp_in0_ready,
  output logic                    dsp_start_valid,
  input  logic                    dsp_start_ready,
  input  logic [SAMPLE_WIDTH-1:0] dsp_out0,
  input  logic                    dsp_out0_valid,
  output logic                    dsp_out0_ready,
  input  logic                    dsp_end_valid,
  output logic                    dsp_end_ready,
  output logic [SAMPLE_WIDTH-1:0] sample_out,
  output logic                    sample_strobe,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StWaitEnd = 2'd2
  } state_e;

  // Watchdog compare value: abort on the WDOG_CYCLES-th busy cycle.
  localparam logic [15:0] WdogLast = 16'(WDOG_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [DIV_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    start_pend_q, start_pend_d;
  logic                    data_pend_q, data_pend_d;
  logic                    end_seen_q, end_seen_d;
  logic [15:0]             wdog_q, wdog_d;
  logic [SAMPLE_WIDTH-1:0] in0_q, in0_d;
  logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
  logic                    strobe_q, strobe_d;
  logic                    overrun_q, overrun_d;
  logic                    timeout_q, timeout_d;

  logic tick;
  logic abort;
  logic start_fire;
  logic data_fire;
  logic start_left;
  logic data_left;

  // Rate counter: counts rate_div..0 while enabled, ticking on 0. Holding it at
  // rate_div while disabled makes the first tick after enable land rate_div cycles
  // after the enabling cycle. A new rate_div is only picked up on reload.
  always_comb begin
    tick = enable && (cnt_q == '0);
    if (!enable || tick) begin
      cnt_d = rate_div;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign abort      = (state_q != StIdle) && (wdog_q == WdogLast);
  assign start_fire = (state_q == StIssue) && start_pend_q && dsp_start_ready;
  assign data_fire  = (state_q == StIssue) && data_pend_q && dsp_in0_ready;
  assign start_left = start_pend_q && !start_fire;
  assign data_left  = data_pend_q && !data_fire;

  // Transaction sequencer.
  always_comb begin
    state_d      = state_q;
    start_pend_d = start_pend_q;
    data_pend_d  = data_pend_q;
    end_seen_d   = end_seen_q;
    in0_d        = in0_q;
    wdog_d       = wdog_q + 16'd1;

    unique case (state_q)
      StIdle: begin
        wdog_d     = '0;
        end_seen_d = 1'b0;
        if (tick) begin
          in0_d        = src_sample;
          start_pend_d = 1'b1;
          data_pend_d  = 1'b1;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        start_pend_d = start_left;
        data_pend_d  = data_left;
        // The core may finish before both tokens are acknowledged; remember it.
        if (dsp_end_valid) begin
          end_seen_d = 1'b1;
        end
        if (!start_left && !data_left) begin
          state_d = (end_seen_q || dsp_end_valid) ? StIdle : StWaitEnd;
        end
      end
      StWaitEnd: begin
        if (dsp_end_valid) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides any token fire in the same cycle.
    if (abort) begin
      state_d      = StIdle;
      start_pend_d = 1'b0;
      data_pend_d  = 1'b0;
    end

    if (state_d == StIdle) begin
      wdog_d = '0;
    end
  end

  // Result capture and sticky flags.
  always_comb begin
    sample_d = dsp_out0_valid ? dsp_out0 : sample_q;
    strobe_d = dsp_out0_valid;

    overrun_d = overrun_q;
    if (tick && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end else if (clr_flags) begin
      overrun_d = 1'b0;
    end

    timeout_d = timeout_q;
    if (abort) begin
      timeout_d = 1'b1;
    end else if (clr_flags) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= rate_div;
      start_pend_q <= 1'b0;
      data_pend_q  <= 1'b0;
      end_seen_q   <= 1'b0;
      wdog_q       <= '0;
      in0_q        <= '0;
      sample_q     <= '0;
      strobe_q     <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      start_pend_q <= start_pend_d;
      data_pend_q  <= data_pend_d;
      end_seen_q   <= end_seen_d;
      wdog_q       <= wdog_d;
      in0_q        <= in0_d;
      sample_q     <= sample_d;
      strobe_q     <= strobe_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  // Handshake outputs are gated by rst so a reset drops them in the same cycle.
  assign src_take        = !rst && tick && (state_q == StIdle);
  assign dsp_start_valid = !rst && (state_q == StIssue) && start_pend_q;
  assign dsp_in0_valid   = !rst && (state_q == StIssue) && data_pend_q;
  assign dsp_in0         = in0_q;
  assign dsp_out0_ready  = 1'b1;
  assign dsp_end_ready   = 1'b1;
  assign sample_out      = sample_q;
  assign sample_strobe   = strobe_q;
  assign busy            = (state_q != StIdle);
  assign overrun         = overrun_q;
  assign timeout         = timeout_q;

endmodule
